disp_write_scheduler: RTL and testbench
=======================================

# disp_write_scheduler

Arbitrates write access to the four display output bits between two requesters: the counter path (debounced, counted value) and the external encoder input. It sits between those sources and the display pins (`hex_out1`..`hex_out4`). A round-robin grant with a req/gnt handshake and a programmable hold-off makes every display update a single, atomic, rate-limited write.

## Interface
- `HOLDOFF`, default 4: idle cycles enforced after each write before the next grant (0 = none).
- `HOLDOFF_W`, default 8: width of the hold-off counter; `HOLDOFF` must fit in it.
- `clk_in`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. All state clears immediately on assertion; release is synchronous to `clk_in`.
- `clr`  in  1  synchronous clear; highest priority after `reset`.
- `req_cnt`  in  1  counter-path write request; held until `gnt_cnt`.
- `data_cnt`  in  2  counter-path value; drives `hex_out1` (bit0) and `hex_out2` (bit1).
- `req_ext`  in  1  encoder-path write request; held until `gnt_ext`.
- `data_ext`  in  2  encoder value; drives `hex_out3` (bit0) and `hex_out4` (bit1).
- `gnt_cnt`  out  1  one-cycle grant to the counter path.
- `gnt_ext`  out  1  one-cycle grant to the encoder path.
- `hex_out1`..`hex_out4`  out  1 each  registered display bits.
- `wr_done`  out  1  one-cycle pulse, high in the cycle the display bits take a new value.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- All outputs are registered. The reset value of every output is 0; `state` resets to IDLE and `last_src` resets to EXT.
- FSM states:
  - IDLE: sample the requests.
    - No request: stay in IDLE.
    - Exactly one request: grant it.
    - Both requests: grant the source that is not `last_src`.
    - On a grant: latch the winner's data, set `gnt_x`=1, update `last_src`, go to WRITE.
  - WRITE: load the latched data into the winner's hex pair only; the other pair holds. Set `wr_done`=1. Go to HOLD with `hold_cnt`=`HOLDOFF`, or to IDLE if `HOLDOFF`=0.
  - HOLD: decrement `hold_cnt`; go to IDLE on the cycle it reaches 0. Requests are ignored but not lost, because requesters keep `req` high.
- Handshake:
  - A requester keeps `req` and `data` stable until it sees `gnt`, and drops `req` in the cycle after `gnt`.
  - `req` still high in IDLE after that counts as a new request.
  - Data is captured at the grant edge, so later changes to `data` do not affect the write.
- `clr`: in any state, go to IDLE, zero all hex outputs, and drop `gnt_*` and `wr_done`. `last_src` is unchanged. A request in the same cycle is not granted.
- `reset` asserted mid-write: the write is aborted, all outputs go to 0 asynchronously, and no partial update is visible.

## Timing
- Request sampled in IDLE at edge k:
  - `gnt_x` high during cycle k→k+1.
  - hex pair and `wr_done` updated at edge k+1.
- Minimum spacing between grants is 2+`HOLDOFF` cycles. With `HOLDOFF`=0, back-to-back alternating grants come every 2 cycles.
- `busy` goes high at edge k and low at the edge where the FSM re-enters IDLE.
- At most one `gnt_*` is high in any cycle. `gnt_*` and `wr_done` are never high in the same cycle.

## Structure
- Shared package `disp_sched_pkg`:
  - state encoding: IDLE=2'b00, WRITE=2'b01, HOLD=2'b10.
  - source IDs: SRC_CNT=1'b0, SRC_EXT=1'b1.
  - `HOLDOFF_W` default.
- One sub-module, `holdoff_timer`: loadable down-counter with ports `clk_in`, `reset`, `load`, `value`, and `zero`. Instantiated once.
- The top-level FSM, the arbiter and the hex registers live in `disp_write_scheduler`.

## Test plan
- Reset then single request: release `reset`; `req_cnt`=1, `data_cnt`=2'b10 → `gnt_cnt` one cycle later; next edge `hex_out2`=1, `hex_out1`=0, `wr_done`=1; `hex_out3`/`hex_out4` stay 0.
- Simultaneous requests: both `req` held high from reset, `data_cnt`=2'b01, `data_ext`=2'b11, `HOLDOFF`=4 → CNT granted first, EXT granted 6 cycles later; final hex bits 1,0,1,1.
- Fairness: both `req` pulse high every IDLE for 8 grants → grants alternate CNT, EXT, CNT…; never two consecutive grants to the same source.
- Hold-off: request arrives during HOLD → no `gnt` until HOLD expires; grant in the first IDLE cycle; `busy` continuous.
- `clr` during WRITE → hex outputs 0, `wr_done` stays 0, FSM in IDLE next cycle, no grant that cycle.
- Async reset mid-HOLD: assert `reset` between edges → all outputs 0 with no clock edge needed; after release, first tie goes to CNT.

Source files
------------

// File: rtl/disp_sched_pkg.sv
// -----------------------------------------------------------------------------
// disp_sched_pkg
// Shared types for the display write scheduler: FSM state encoding, requester
// source IDs, the default hold-off counter width and the round-robin pick.
// -----------------------------------------------------------------------------
package disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    HOLD  = 2'b10
  } state_t;

  typedef enum logic {
    SRC_CNT = 1'b0,
    SRC_EXT = 1'b1
  } src_t;

  localparam int HOLDOFF_W_DEF = 8;

  // A tie goes to whichever source did not win last time.
  function automatic src_t pick_winner(input logic req_cnt, input logic req_ext,
                                       input src_t last_src);
    if (req_cnt && req_ext) return (last_src == SRC_CNT) ? SRC_EXT : SRC_CNT;
    return req_cnt ? SRC_CNT : SRC_EXT;
  endfunction

endpackage

// File: rtl/disp_write_scheduler_holdoff_timer.sv
// -----------------------------------------------------------------------------
// holdoff_timer
// Loadable down-counter that paces the scheduler's HOLD state.
//   clk_in : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   load   : load `value` into the counter
//   value  : hold-off length in cycles
//   zero   : the counter reaches zero at the coming clock edge
// -----------------------------------------------------------------------------
module holdoff_timer
  import disp_sched_pkg::*;
#(
  parameter int HOLDOFF_W = HOLDOFF_W_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 load,
  input  logic [HOLDOFF_W-1:0] value,
  output logic                 zero
);

  logic [HOLDOFF_W-1:0] count;

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - HOLDOFF_W'(1);
    end
  end

  // Flagged one cycle early so the FSM leaves HOLD on the very edge at which
  // the count hits zero, giving exactly `value` HOLD cycles.
  assign zero = (count == HOLDOFF_W'(1));

endmodule

// File: rtl/disp_write_scheduler.sv
// -----------------------------------------------------------------------------
// disp_write_scheduler
// Round-robin arbiter that gives the counter path and the encoder path atomic,
// rate-limited write access to the four display bits.
//   clk_in, reset       : clock (rising edge), async active-low reset
//   clr                 : synchronous clear, back to IDLE with hex bits zeroed
//   req_cnt / data_cnt  : counter-path request and value (-> hex_out1/hex_out2)
//   req_ext / data_ext  : encoder-path request and value (-> hex_out3/hex_out4)
//   gnt_cnt / gnt_ext   : one-cycle grants
//   hex_out1..hex_out4  : registered display bits
//   wr_done             : pulses in the cycle the display bits change
//   busy                : FSM is not in IDLE
// -----------------------------------------------------------------------------
module disp_write_scheduler
  import disp_sched_pkg::*;
#(
  parameter int HOLDOFF   = 4,
  parameter int HOLDOFF_W = HOLDOFF_W_DEF
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clr,
  input  logic       req_cnt,
  input  logic [1:0] data_cnt,
  input  logic       req_ext,
  input  logic [1:0] data_ext,
  output logic       gnt_cnt,
  output logic       gnt_ext,
  output logic       hex_out1,
  output logic       hex_out2,
  output logic       hex_out3,
  output logic       hex_out4,
  output logic       wr_done,
  output logic       busy
);

  state_t     state;
  src_t       last_src;
  src_t       win_src;
  src_t       winner;
  logic [1:0] data_lat;
  logic       timer_load;
  logic       timer_zero;

  assign winner     = pick_winner(req_cnt, req_ext, last_src);
  assign timer_load = (state == WRITE) && !clr && (HOLDOFF != 0);

  holdoff_timer #(
    .HOLDOFF_W (HOLDOFF_W)
  ) u_holdoff_timer (
    .clk_in (clk_in),
    .reset  (reset),
    .load   (timer_load),
    .value  (HOLDOFF_W'(HOLDOFF)),
    .zero   (timer_zero)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_src <= SRC_EXT;
      win_src  <= SRC_CNT;
      data_lat <= '0;
      gnt_cnt  <= 1'b0;
      gnt_ext  <= 1'b0;
      wr_done  <= 1'b0;
      busy     <= 1'b0;
      hex_out1 <= 1'b0;
      hex_out2 <= 1'b0;
      hex_out3 <= 1'b0;
      hex_out4 <= 1'b0;
    end else begin
      // NOTE: the pulse outputs default low here; any branch below that
      // wants them high overrides the default for this cycle only.
      gnt_cnt <= 1'b0;
      gnt_ext <= 1'b0;
      wr_done <= 1'b0;
      if (clr) begin
        // last_src deliberately survives a clear so fairness is preserved.
        state    <= IDLE;
        busy     <= 1'b0;
        hex_out1 <= 1'b0;
        hex_out2 <= 1'b0;
        hex_out3 <= 1'b0;
        hex_out4 <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_cnt || req_ext) begin
              // Data is captured here so the requester may change it freely
              // once it has seen its grant.
              win_src  <= winner;
              last_src <= winner;
              data_lat <= (winner == SRC_EXT) ? data_ext : data_cnt;
              gnt_cnt  <= (winner == SRC_CNT);
              gnt_ext  <= (winner == SRC_EXT);
              busy     <= 1'b1;
              state    <= WRITE;
            end
          end
          WRITE: begin
            if (win_src == SRC_CNT) {hex_out2, hex_out1} <= data_lat;
            else                    {hex_out4, hex_out3} <= data_lat;
            wr_done <= 1'b1;
            if (HOLDOFF == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end
          HOLD: begin
            if (timer_zero) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disp_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_disp_write_scheduler
// Scoreboard bench for disp_write_scheduler (HOLDOFF = 4). Stimulus pushes the
// expected grants and writes; a negedge monitor pops and compares them whenever
// the DUT pulses a grant or wr_done. Requester agents follow the req/gnt
// handshake; a few directed checks cover reset, clear and hold-off behaviour.
// -----------------------------------------------------------------------------
module tb_disp_write_scheduler;

  typedef struct {
    bit         is_write;
    bit         src;       // 0 = counter path, 1 = encoder path
    logic [3:0] hex;       // {hex_out4, hex_out3, hex_out2, hex_out1}
    int         gap;       // required cycles since previous grant, 0 = any
  } exp_t;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       req_cnt = 1'b0;
  logic [1:0] data_cnt = 2'b00;
  logic       req_ext = 1'b0;
  logic [1:0] data_ext = 2'b00;
  logic       gnt_cnt, gnt_ext, wr_done, busy;
  logic       hex_out1, hex_out2, hex_out3, hex_out4;

  exp_t       exp_q[$];
  logic [1:0] q_cnt[$];
  logic [1:0] q_ext[$];
  logic [3:0] exp_hex = 4'b0000;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_gnt = 0;
  bit         agent_on = 1'b0;
  bit         seen_cnt = 1'b0;
  bit         seen_ext = 1'b0;
  logic [1:0] cd[4] = '{2'b00, 2'b11, 2'b10, 2'b01};
  logic [1:0] ed[4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  disp_write_scheduler #(
    .HOLDOFF   (4),
    .HOLDOFF_W (8)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .clr      (clr),
    .req_cnt  (req_cnt),
    .data_cnt (data_cnt),
    .req_ext  (req_ext),
    .data_ext (data_ext),
    .gnt_cnt  (gnt_cnt),
    .gnt_ext  (gnt_ext),
    .hex_out1 (hex_out1),
    .hex_out2 (hex_out2),
    .hex_out3 (hex_out3),
    .hex_out4 (hex_out4),
    .wr_done  (wr_done),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic exp_grant(input bit src, input int gap);
    exp_q.push_back('{is_write: 1'b0, src: src, hex: 4'b0000, gap: gap});
  endtask

  task automatic exp_write(input bit src, input logic [1:0] d);
    if (src) exp_hex[3:2] = d;
    else     exp_hex[1:0] = d;
    exp_q.push_back('{is_write: 1'b1, src: src, hex: exp_hex, gap: 0});
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return gnt_cnt;
      1:       return gnt_ext;
      default: return wr_done;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    int n = 0;
    while (!sig_of(which) && n < 40) begin
      tick();
      n++;
    end
    check(name, {31'b0, sig_of(which)}, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || req_cnt || req_ext ||
            q_cnt.size() != 0 || q_ext.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check(name, {31'b0, n < 200}, 1);
  endtask

  // Requester agents: raise req with queued data, hold until gnt, drop req in
  // the following cycle and scramble data to prove it was captured at grant.
  initial forever begin
    @(posedge clk_in);
    #1;
    if (agent_on) begin
      if (req_cnt && gnt_cnt) seen_cnt = 1'b1;
      else if (req_cnt && seen_cnt) begin
        seen_cnt = 1'b0;
        req_cnt  = 1'b0;
        data_cnt = ~data_cnt;
      end else if (!req_cnt && !seen_cnt && q_cnt.size() > 0) begin
        data_cnt = q_cnt.pop_front();
        req_cnt  = 1'b1;
      end
      if (req_ext && gnt_ext) seen_ext = 1'b1;
      else if (req_ext && seen_ext) begin
        seen_ext = 1'b0;
        req_ext  = 1'b0;
        data_ext = ~data_ext;
      end else if (!req_ext && !seen_ext && q_ext.size() > 0) begin
        data_ext = q_ext.pop_front();
        req_ext  = 1'b1;
      end
    end
  end

  // Monitor: compares every grant and every write against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (gnt_cnt || gnt_ext) begin
        check("gnt_exclusive", {30'b0, wr_done, gnt_cnt & gnt_ext}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", {30'b0, gnt_ext, gnt_cnt}, 0);
        end else begin
          e = exp_q.pop_front();
          check("gnt_kind", {31'b0, e.is_write}, 0);
          check("gnt_src", {30'b0, gnt_ext, gnt_cnt}, e.src ? 2 : 1);
          if (e.gap != 0) check("gnt_gap", cyc - last_gnt, e.gap);
        end
        last_gnt = cyc;
      end
      if (wr_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", {31'b0, wr_done}, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_kind", {31'b0, e.is_write}, 1);
          check("wr_hex", {28'b0, hex_out4, hex_out3, hex_out2, hex_out1}, e.hex);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then a single counter-path request.
    tick();
    check("reset_outs", {24'b0, gnt_cnt, gnt_ext, wr_done, busy,
                         hex_out4, hex_out3, hex_out2, hex_out1}, 0);
    reset = 1'b1;
    exp_grant(0, 0);
    exp_write(0, 2'b10);
    agent_on = 1'b1;
    q_cnt.push_back(2'b10);
    wait_idle("t1_done");

    // Both requests held from reset: tie goes to CNT, EXT six cycles later.
    reset   = 1'b0;
    exp_hex = 4'b0000;
    exp_grant(0, 0);
    exp_write(0, 2'b01);
    exp_grant(1, 6);
    exp_write(1, 2'b11);
    q_cnt.push_back(2'b01);
    q_ext.push_back(2'b11);
    tick();
    tick();
    reset = 1'b1;
    wait_idle("t2_done");
    check("t2_final_hex", {28'b0, hex_out4, hex_out3, hex_out2, hex_out1}, 4'b1101);

    // Fairness: both requesters re-request continuously for 8 grants.
    for (int i = 0; i < 4; i++) begin
      exp_grant(0, (i == 0) ? 0 : 6);
      exp_write(0, cd[i]);
      exp_grant(1, 6);
      exp_write(1, ed[i]);
      q_cnt.push_back(cd[i]);
      q_ext.push_back(ed[i]);
    end
    wait_idle("t3_done");

    // Hold-off: an EXT request arriving in HOLD waits for the first IDLE cycle.
    exp_grant(0, 0);
    exp_write(0, 2'b11);
    exp_grant(1, 6);
    exp_write(1, 2'b10);
    q_cnt.push_back(2'b11);
    wait_sig(0, "t4_gnt_cnt");
    for (int i = 0; i < 5; i++) begin
      check("t4_busy", {31'b0, busy}, 1);
      if (i == 2) q_ext.push_back(2'b10);
      tick();
    end
    wait_idle("t4_done");

    // clr during WRITE: no write, back to IDLE, request under clr not granted.
    agent_on = 1'b0;
    tick();
    exp_grant(0, 0);
    data_cnt = 2'b01;
    req_cnt  = 1'b1;
    wait_sig(0, "t5_gnt");
    clr = 1'b1;
    tick();
    check("t5_clr_outs", {29'b0, wr_done, busy, |{hex_out4, hex_out3, hex_out2, hex_out1}}, 0);
    tick();
    check("t5_no_gnt", {30'b0, gnt_cnt, busy}, 0);
    clr     = 1'b0;
    req_cnt = 1'b0;
    exp_hex = 4'b0000;
    wait_idle("t5_done");

    // Async reset mid-HOLD, then the first tie after release goes to CNT.
    agent_on = 1'b1;
    exp_grant(1, 0);
    exp_write(1, 2'b11);
    q_ext.push_back(2'b11);
    wait_sig(2, "t6_wr");
    tick();
    tick();
    agent_on = 1'b0;
    check("t6_busy_pre", {31'b0, busy}, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_outs", {24'b0, gnt_cnt, gnt_ext, wr_done, busy,
                            hex_out4, hex_out3, hex_out2, hex_out1}, 0);
    exp_hex  = 4'b0000;
    data_cnt = 2'b10;
    data_ext = 2'b01;
    req_cnt  = 1'b1;
    req_ext  = 1'b1;
    exp_grant(0, 0);
    exp_write(0, 2'b10);
    tick();
    tick();
    reset = 1'b1;
    wait_sig(0, "t6_tie_cnt");
    tick();
    req_cnt = 1'b0;
    req_ext = 1'b0;
    wait_idle("t6_done");

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
